// File: rtl/period_meter_pkg.sv
// Shared types and helpers for period_meter: counter width function, cycle-count
// helpers for timeout constants, and FSM state encoding (PERIOD_METER_FILT_EN aware blocks import this).
package period_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam longint CLK_HZ_DEFAULT = 100_000_000;

  // Bits needed to hold the value v itself (not v-1).
  function automatic int cbit(input longint v);
    int w;
    w = 1;
    while ((w < 63) && ((longint'(1) << w) <= v)) w = w + 1;
    return w;
  endfunction

  function automatic longint c_ms(input longint clk_hz, input longint ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic longint c_us(input longint clk_hz, input longint us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchronizes sig_in, optionally glitch-filters it (PERIOD_METER_FILT_EN), and emits a rising-edge pulse.
// Latency: SYNC_STAGES cycles to the level (+FILT when filtered); rise is combinational on that level.
module period_meter_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  if ((SYNC_STAGES < 2) || (FILT < 1)) begin : g_bad_cfg
    $error("period_meter_edge_sync: SYNC_STAGES must be >= 2 and FILT >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

`ifdef PERIOD_METER_FILT_EN
  localparam int FW = $clog2(FILT + 1);

  logic          r_filt;
  logic [FW-1:0] r_fcnt;

  // The level flips only after FILT consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILT - 1)) begin
      r_filt <= r_sync[SYNC_STAGES-1];
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_s;
  end

  assign o_rise = w_s & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-to-rising period of async sig_in in clk cycles; sticky timeout after TMAX idle cycles.
// Latency sig_in rise -> period_vld: SYNC_STAGES+1 cycles (+FILT with PERIOD_METER_FILT_EN); no backpressure.
module period_meter
  import period_meter_pkg::*;
#(
  parameter  int TMAX        = 100_000_000,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILT        = 4,
  localparam int CBIT        = cbit(longint'(TMAX))
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig_in,
  output logic [CBIT-1:0] period,
  output logic            period_vld,
  output logic            locked,
  output logic            timeout
);

  localparam logic [CBIT-1:0] TMAX_C = CBIT'(TMAX);

  logic w_rise;

  state_t          r_state, w_state_nxt;
  logic [CBIT-1:0] r_cnt, w_cnt_nxt;
  logic [CBIT-1:0] r_period, w_period_nxt;
  logic            r_vld, w_vld_nxt;
  logic            r_locked, w_locked_nxt;
  logic            r_timeout, w_timeout_nxt;

  period_meter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT       (FILT)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_sig (sig_in),
    .o_rise(w_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_vld     <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_vld     <= w_vld_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_vld_nxt     = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt   = ST_RUN;
          w_cnt_nxt     = CBIT'(1);
          w_timeout_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        // A rise on the TMAX cycle still counts as a valid period.
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_vld_nxt    = 1'b1;
          w_locked_nxt = 1'b1;
          w_cnt_nxt    = CBIT'(1);
        end else if (r_cnt == TMAX_C) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_locked_nxt  = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CBIT'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign period     = r_period;
  assign period_vld = r_vld;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TMAX=64; expectations follow the build's PERIOD_METER_FILT_EN setting.
module tb_period_meter;

  localparam int TMAX        = 64;
  localparam int SYNC_STAGES = 2;
  localparam int FILT        = 4;
  localparam int CBIT        = 7;
`ifdef PERIOD_METER_FILT_EN
  localparam int LAT = SYNC_STAGES + 1 + FILT;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sig_in;
  logic [CBIT-1:0] period;
  logic            period_vld;
  logic            locked;
  logic            timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int last_vld_cyc = 0;
  int prev_vld_cyc = 0;
  int rise_cyc = 0;
  int base = 0;

  period_meter #(
    .TMAX       (TMAX),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT       (FILT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .period_vld(period_vld),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_vld === 1'b1) begin
      vld_cnt      = vld_cnt + 1;
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
    end
  end

  // Rise at the current point (just after an edge), high for hi edges, low for lo edges.
  task automatic run_period(input int hi, input int lo);
    rise_cyc = cyc;
    sig_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (period !== '0)      begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
    n_cmp++; if (period_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", period_vld); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (timeout !== 1'b0)   begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    base = vld_cnt;
    run_period(5, 5);
    n_cmp++; if (vld_cnt - base !== 0) begin n_bad++; $display("FAIL first_rise_vld: got %0d pulses want 0", vld_cnt - base); end
    n_cmp++; if (locked !== 1'b0)      begin n_bad++; $display("FAIL first_rise_locked: got %b want 0", locked); end
    run_period(5, 5);
    n_cmp++; if (last_vld_cyc - rise_cyc !== LAT) begin n_bad++; $display("FAIL latency: got %0d want %0d", last_vld_cyc - rise_cyc, LAT); end
    run_period(5, 5);
    run_period(5, 5);
    n_cmp++; if (vld_cnt - base !== 3) begin n_bad++; $display("FAIL basic_vld_count: got %0d want 3", vld_cnt - base); end
    n_cmp++; if (period !== 7'd10)     begin n_bad++; $display("FAIL basic_period: got %0d want 10", period); end
    n_cmp++; if (locked !== 1'b1)      begin n_bad++; $display("FAIL basic_locked: got %b want 1", locked); end
    n_cmp++; if (last_vld_cyc - prev_vld_cyc !== 10) begin n_bad++; $display("FAIL basic_spacing: got %0d want 10", last_vld_cyc - prev_vld_cyc); end
  endtask

  task automatic test_interval_change;
    base = vld_cnt;
    for (int i = 0; i < 4; i++) run_period(7, 7);
    n_cmp++; if (vld_cnt - base !== 4) begin n_bad++; $display("FAIL interval_vld_count: got %0d want 4", vld_cnt - base); end
    n_cmp++; if (period !== 7'd14)     begin n_bad++; $display("FAIL interval_period: got %0d want 14", period); end
    n_cmp++; if (last_vld_cyc - prev_vld_cyc !== 14) begin n_bad++; $display("FAIL interval_spacing: got %0d want 14", last_vld_cyc - prev_vld_cyc); end
  endtask

  task automatic test_timeout;
    run_period(5, 5);
    run_period(5, 5);
    base = vld_cnt;
    sig_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (LAT + TMAX - 1 - 5) @(posedge clk);
    #1;
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", timeout); end
    n_cmp++; if (locked !== 1'b1)  begin n_bad++; $display("FAIL timeout_early_locked: got %b want 1", locked); end
    @(posedge clk);
    #1;
    n_cmp++; if (timeout !== 1'b1)     begin n_bad++; $display("FAIL timeout_set: got %b want 1", timeout); end
    n_cmp++; if (locked !== 1'b0)      begin n_bad++; $display("FAIL timeout_locked: got %b want 0", locked); end
    n_cmp++; if (period !== 7'd10)     begin n_bad++; $display("FAIL timeout_period_hold: got %0d want 10", period); end
    n_cmp++; if (vld_cnt - base !== 1) begin n_bad++; $display("FAIL timeout_vld_count: got %0d want 1", vld_cnt - base); end
    repeat (4) @(posedge clk);
    #1;
    base = vld_cnt;
    run_period(5, 5);
    n_cmp++; if (timeout !== 1'b0)     begin n_bad++; $display("FAIL resume_timeout: got %b want 0", timeout); end
    n_cmp++; if (vld_cnt - base !== 0) begin n_bad++; $display("FAIL resume_first_vld: got %0d want 0", vld_cnt - base); end
    n_cmp++; if (locked !== 1'b0)      begin n_bad++; $display("FAIL resume_first_locked: got %b want 0", locked); end
    run_period(6, 6);
    n_cmp++; if (vld_cnt - base !== 1) begin n_bad++; $display("FAIL resume_second_vld: got %0d want 1", vld_cnt - base); end
    n_cmp++; if (period !== 7'd10)     begin n_bad++; $display("FAIL resume_period: got %0d want 10", period); end
    n_cmp++; if (locked !== 1'b1)      begin n_bad++; $display("FAIL resume_locked: got %b want 1", locked); end
  endtask

  task automatic test_tmax_boundary;
    run_period(32, 32);
    base = vld_cnt;
    run_period(32, 32);
    n_cmp++; if (vld_cnt - base !== 1) begin n_bad++; $display("FAIL tmax_vld: got %0d want 1", vld_cnt - base); end
    n_cmp++; if (period !== 7'd64)     begin n_bad++; $display("FAIL tmax_period: got %0d want 64", period); end
    n_cmp++; if (timeout !== 1'b0)     begin n_bad++; $display("FAIL tmax_timeout: got %b want 0", timeout); end
    n_cmp++; if (locked !== 1'b1)      begin n_bad++; $display("FAIL tmax_locked: got %b want 1", locked); end
  endtask

  task automatic test_reset_mid;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (period !== '0)       begin n_bad++; $display("FAIL midrst_period: got %0d want 0", period); end
    n_cmp++; if (period_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_vld: got %b want 0", period_vld); end
    n_cmp++; if (locked !== 1'b0)     begin n_bad++; $display("FAIL midrst_locked: got %b want 0", locked); end
    n_cmp++; if (timeout !== 1'b0)    begin n_bad++; $display("FAIL midrst_timeout: got %b want 0", timeout); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = vld_cnt;
    run_period(5, 5);
    n_cmp++; if (vld_cnt - base !== 0) begin n_bad++; $display("FAIL midrst_first_vld: got %0d want 0", vld_cnt - base); end
    run_period(5, 5);
    run_period(5, 5);
    n_cmp++; if (vld_cnt - base !== 2) begin n_bad++; $display("FAIL midrst_vld_count: got %0d want 2", vld_cnt - base); end
    n_cmp++; if (period !== 7'd10)     begin n_bad++; $display("FAIL midrst_period_after: got %0d want 10", period); end
  endtask

  task automatic test_glitch;
    int exp_cnt;
    int exp_period;
`ifdef PERIOD_METER_FILT_EN
    exp_cnt    = 2;
    exp_period = 20;
`else
    exp_cnt    = 3;
    exp_period = 6;
`endif
    run_period(10, 10);
    run_period(10, 10);
    base = vld_cnt;
    sig_in = 1'b1;
    repeat (10) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    run_period(10, 10);
    n_cmp++; if (vld_cnt - base !== exp_cnt) begin n_bad++; $display("FAIL glitch_vld_count: got %0d want %0d", vld_cnt - base, exp_cnt); end
    n_cmp++; if (period !== CBIT'(exp_period)) begin n_bad++; $display("FAIL glitch_period: got %0d want %0d", period, exp_period); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_interval_change;
    test_timeout;
    test_tmax_boundary;
    test_reset_mid;
    test_glitch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
